// File: rtl/osnt_multi_bram_output_queues.sv
// Multi-queue packet buffer: one ingress stream is steered into per-queue data/metadata FIFOs
// by the destination bits in tuser; a packet that does not fit in every selected queue is dropped whole.
//
// Ingress FSM
//   state  | meaning
//   IDLE   | waiting for a packet head; destination and drop decision taken here
//   WR_PKT | accepting beats into every selected queue
//   DROP   | accepting and discarding beats until tlast
// Per-queue metadata FSM
//   WAIT_HEADER | next egress word is a packet head; tuser shown from the FIFO head
//   WAIT_EOP    | inside a packet; tuser shown from the latched copy

module fallthrough_small_fifo #(
    parameter int WIDTH            = 8,
    parameter int DEPTH            = 16,
    parameter int PROG_FULL_THRESH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             prog_full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = wr_en_i & (count_q != CW'(DEPTH));
    assign rd_ok = rd_en_i & (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din_i;
    end

    // Head word is visible combinationally so egress adds no latency.
    assign dout_o      = mem_q[rd_ptr_q];
    assign empty_o     = (count_q == '0);
    assign prog_full_o = (count_q >= CW'(PROG_FULL_THRESH));
endmodule

module osnt_multi_bram_output_queues #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES           = 4,
    parameter int BUFFER_SIZE          = 4096,
    parameter int MAX_PACKET_SIZE      = 1600,
    parameter int DST_POS              = 24
) (
    input  logic                                         axi_aclk,
    input  logic                                         axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]               s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]             s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]              s_axis_tuser,
    input  logic                                         s_axis_tvalid,
    input  logic                                         s_axis_tlast,
    output logic                                         s_axis_tready,
    output logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [NUM_QUEUES*C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [NUM_QUEUES-1:0]                        m_axis_tvalid,
    output logic [NUM_QUEUES-1:0]                        m_axis_tlast,
    input  logic [NUM_QUEUES-1:0]                        m_axis_tready,
    output logic [31:0]                                  drop_count,
    output logic                                         drop_pulse
);
    localparam int DW     = C_S_AXIS_DATA_WIDTH;
    localparam int BW     = DW / 8;
    localparam int UW     = C_S_AXIS_TUSER_WIDTH;
    localparam int MDW    = C_M_AXIS_DATA_WIDTH;
    localparam int MUW    = C_M_AXIS_TUSER_WIDTH;
    localparam int WORDS  = BUFFER_SIZE / BW;
    localparam int THRESH = (BUFFER_SIZE - MAX_PACKET_SIZE) / BW;
    localparam int FW     = 1 + BW + DW;

    typedef enum logic [1:0] {IDLE, WR_PKT, DROP} in_state_t;
    typedef enum logic {WAIT_HEADER, WAIT_EOP} meta_state_t;

    in_state_t             state_q, state_d;
    logic [NUM_QUEUES-1:0] dst_q, dst_d;
    logic                  first_q, first_d;
    logic [NUM_QUEUES-1:0] busy_q, busy_d;
    logic [NUM_QUEUES-1:0] oq;
    logic [NUM_QUEUES-1:0] wr_data;
    logic [NUM_QUEUES-1:0] wr_meta;
    logic                  tready;
    logic                  drop_evt;
    logic [31:0]           drop_count_q;
    logic                  drop_pulse_q;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_oq
        assign oq[g] = s_axis_tuser[DST_POS+2*g] | s_axis_tuser[DST_POS+2*g+1];
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q      <= IDLE;
            dst_q        <= '0;
            first_q      <= 1'b0;
            busy_q       <= '0;
            drop_count_q <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dst_q        <= dst_d;
            first_q      <= first_d;
            busy_q       <= busy_d;
            drop_pulse_q <= drop_evt;
            if (drop_evt && (drop_count_q != 32'hFFFF_FFFF))
                drop_count_q <= drop_count_q + 32'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        dst_d    = dst_q;
        first_d  = first_q;
        tready   = 1'b0;
        wr_data  = '0;
        wr_meta  = '0;
        drop_evt = 1'b0;
        case (state_q)
            IDLE: begin
                // The head beat is not consumed here; it is taken in WR_PKT or DROP.
                if (s_axis_tvalid) begin
                    dst_d   = oq;
                    first_d = 1'b1;
                    if ((oq != '0) && ((busy_q & oq) == '0)) state_d = WR_PKT;
                    else                                     state_d = DROP;
                end
            end
            WR_PKT: begin
                tready = 1'b1;
                if (s_axis_tvalid) begin
                    wr_data = dst_q;
                    if (first_q) wr_meta = dst_q;
                    first_d = 1'b0;
                    if (s_axis_tlast) state_d = IDLE;
                end
            end
            DROP: begin
                tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d  = IDLE;
                    drop_evt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_axis_tready = tready & ~axi_reset;
    assign drop_count    = axi_reset ? 32'd0 : drop_count_q;
    assign drop_pulse    = drop_pulse_q & ~axi_reset;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
        logic [FW-1:0] data_dout;
        logic          data_empty;
        logic          data_prog_full;
        logic [UW-1:0] meta_dout;
        logic          meta_empty;
        logic          meta_nearly_full;
        logic          rd_en;
        logic          meta_rd;
        logic          pkt_last;
        meta_state_t   ms_q, ms_d;
        logic [UW-1:0] tuser_q, tuser_d;

        fallthrough_small_fifo #(
            .WIDTH            (FW),
            .DEPTH            (WORDS),
            .PROG_FULL_THRESH (THRESH)
        ) u_data_fifo (
            .clk_i       (axi_aclk),
            .rst_i       (axi_reset),
            .din_i       ({s_axis_tlast, s_axis_tstrb, s_axis_tdata}),
            .wr_en_i     (wr_data[g]),
            .rd_en_i     (rd_en),
            .dout_o      (data_dout),
            .empty_o     (data_empty),
            .prog_full_o (data_prog_full)
        );

        // Four-entry metadata store; "nearly full" once three headers are queued.
        fallthrough_small_fifo #(
            .WIDTH            (UW),
            .DEPTH            (4),
            .PROG_FULL_THRESH (3)
        ) u_meta_fifo (
            .clk_i       (axi_aclk),
            .rst_i       (axi_reset),
            .din_i       (s_axis_tuser),
            .wr_en_i     (wr_meta[g]),
            .rd_en_i     (meta_rd),
            .dout_o      (meta_dout),
            .empty_o     (meta_empty),
            .prog_full_o (meta_nearly_full)
        );

        assign busy_d[g]        = data_prog_full | meta_nearly_full;
        assign pkt_last         = data_dout[FW-1];
        assign m_axis_tvalid[g] = ~data_empty & ~axi_reset;
        assign rd_en            = m_axis_tready[g] & m_axis_tvalid[g];

        assign m_axis_tdata[g*MDW +: MDW]        = data_dout[DW-1:0];
        assign m_axis_tstrb[g*(MDW/8) +: MDW/8]  = data_dout[DW +: BW];
        assign m_axis_tlast[g]                   = pkt_last;
        // The header is popped on the first word, so later words use the latched copy.
        assign m_axis_tuser[g*MUW +: MUW]        = (ms_q == WAIT_EOP) ? tuser_q : meta_dout;

        always_ff @(posedge axi_aclk) begin
            if (axi_reset) begin
                ms_q    <= WAIT_HEADER;
                tuser_q <= '0;
            end else begin
                ms_q    <= ms_d;
                tuser_q <= tuser_d;
            end
        end

        always_comb begin
            ms_d    = ms_q;
            tuser_d = tuser_q;
            meta_rd = 1'b0;
            case (ms_q)
                WAIT_HEADER: begin
                    if (rd_en) begin
                        meta_rd = ~meta_empty;
                        tuser_d = meta_dout;
                        // A single-word packet is complete on its header pop.
                        ms_d    = pkt_last ? WAIT_HEADER : WAIT_EOP;
                    end
                end
                WAIT_EOP: begin
                    if (rd_en && pkt_last) ms_d = WAIT_HEADER;
                end
                default: ms_d = WAIT_HEADER;
            endcase
        end
    end
endmodule
